// File: rtl/noise_acq_mc.sv
// -----------------------------------------------------------------------------
// noise_acq_mc
// Multi-channel noise acquisition block. Divides clk_sys into a programmable
// ADC sample clock, captures NUM_CH channel samples on each sample strobe and
// writes them channel-interleaved (ch0 first) into an internal buffer RAM. When
// the acquisition is idle, the host reads the buffer one word at a time.
//
// Optional feature macro: NOISE_ACQ_MC_ACCUM_EN
//   When defined, adds input n_scans. The acquisition repeats n_scans times
//   (0 counts as 1). Later scans add each sample into the stored word. Each
//   channel then needs a 2-cycle read-modify-write, so the divisor floor is
//   2*NUM_CH+1 instead of NUM_CH+1.
//
// Ports:
//   clk_sys        in   system clock
//   reset          in   asynchronous active-high reset
//   noise_load     in   1-cycle pulse: latch n_acqnum/n_divnum, (re)start run
//   n_acqnum       in   samples per channel to acquire
//   n_divnum       in   clk_sys cycles per sample strobe
//   n_ADC          in   channel samples, ch0 in the LSBs
//   n_scans        in   scan repeat count (NOISE_ACQ_MC_ACCUM_EN only)
//   RAM_RD_EN      in   readout request, one word per asserted cycle
//   RAM_RDaddr_rst in   synchronous clear of the read address
//   Noise_acq_clk  out  divided sample clock to the ADC
//   RAM_data       out  readout word
//   rd_valid       out  RAM_data valid, one cycle after an accepted read
//   busy           out  acquisition in progress
//   done           out  acquisition complete, cleared by the next noise_load
//   overflow       out  request exceeded buffer depth, sticky until noise_load
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module noise_acq_mc #(
    parameter int NUM_CH = 2,
    parameter int ADC_W  = 12,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 12,
    parameter int DIV_W  = 10
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     noise_load,
    input  logic [CNT_W-1:0]         n_acqnum,
    input  logic [DIV_W-1:0]         n_divnum,
    input  logic [NUM_CH*ADC_W-1:0]  n_ADC,
`ifdef NOISE_ACQ_MC_ACCUM_EN
    input  logic [7:0]               n_scans,
`endif
    input  logic                     RAM_RD_EN,
    input  logic                     RAM_RDaddr_rst,
    output logic                     Noise_acq_clk,
    output logic [DATA_W-1:0]        RAM_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LIM_W       = (CNT_W > ADDR_W) ? CNT_W + 1 : ADDR_W + 1;
    localparam int MAX_SAMPLES = (2 ** ADDR_W) / NUM_CH;
`ifdef NOISE_ACQ_MC_ACCUM_EN
    localparam int D_MIN       = 2 * NUM_CH + 1;
`else
    localparam int D_MIN       = NUM_CH + 1;
`endif
    localparam logic [DIV_W-1:0] D_MIN_C   = DIV_W'(D_MIN);
    localparam logic [LIM_W-1:0] MAX_C     = LIM_W'(MAX_SAMPLES);
    localparam logic [CH_W-1:0]  LAST_CH_C = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                     state_r, state_s;
    logic [DIV_W-1:0]           div_r, div_cnt_r, cnt_nxt_s;
    logic [LIM_W-1:0]           limit_r, sample_idx_r, acq_ext_s;
    logic [ADDR_W-1:0]          wr_addr_r, rd_addr_r;
    logic [CH_W-1:0]            ch_r;
    logic [NUM_CH*ADC_W-1:0]    hold_r;
    logic [ADC_W-1:0]           sample_s;
    logic [DATA_W-1:0]          wdata_s, ram_data_r;
    logic [DATA_W-1:0]          mem_r [2**ADDR_W];
    logic                       rd_valid_r, busy_r, done_r, overflow_r, acq_clk_r;
    logic                       strobe_s, step_s, scan_end_s, run_end_s;
    logic                       arm_s, mem_we_s, busy_nxt_s, acq_clk_nxt_s, rd_take_s;
`ifdef NOISE_ACQ_MC_ACCUM_EN
    logic [7:0]                 scans_r, scan_r;
    logic                       phase_r;
    logic [DATA_W-1:0]          rmw_word_r;
`endif

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Decodes: channel mux, sample strobe, channel step, end of scan/run, divider next count
    always_comb begin
        acq_ext_s = LIM_W'(n_acqnum);
        sample_s  = {ADC_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sample_s = (ch_r == CH_W'(i)) ? hold_r[i*ADC_W +: ADC_W] : sample_s;
        end
        strobe_s = (state_r == ST_WAIT) && (div_cnt_r == div_r - DIV_W'(1));
`ifdef NOISE_ACQ_MC_ACCUM_EN
        // second cycle of the read-modify-write completes a channel
        step_s    = (state_r == ST_WRITE) && phase_r;
        run_end_s = (scan_r + 8'd1 == scans_r);
`else
        step_s    = (state_r == ST_WRITE);
        run_end_s = 1'b1;
`endif
        scan_end_s = step_s && (ch_r == LAST_CH_C) && (sample_idx_r + LIM_W'(1) == limit_r);
        if ((state_r == ST_WAIT) || (state_r == ST_WRITE)) begin
            cnt_nxt_s = (div_cnt_r == div_r - DIV_W'(1)) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
        end else begin
            cnt_nxt_s = {DIV_W{1'b0}};
        end
    end

    // Next-state logic; noise_load restarts from any state
    always_comb begin
        state_s = state_r;
        if (noise_load) begin
            state_s = ST_ARM;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = ST_IDLE;
                ST_ARM:   state_s = (limit_r == {LIM_W{1'b0}}) ? ST_DONE : ST_WAIT;
                ST_WAIT:  state_s = strobe_s ? ST_WRITE : ST_WAIT;
                ST_WRITE: begin
                    if (step_s && (ch_r == LAST_CH_C)) begin
                        state_s = (scan_end_s && run_end_s) ? ST_DONE : ST_WAIT;
                    end else begin
                        state_s = ST_WRITE;
                    end
                end
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Output/control decodes feeding the registered outputs and the RAM
    always_comb begin
        arm_s         = (state_r == ST_ARM);
        mem_we_s      = step_s;
        busy_nxt_s    = (state_s == ST_ARM) || (state_s == ST_WAIT) || (state_s == ST_WRITE);
        // high for the first floor(D/2) counts; count 0 follows the strobe
        acq_clk_nxt_s = ((state_s == ST_WAIT) || (state_s == ST_WRITE)) &&
                        (cnt_nxt_s < {1'b0, div_r[DIV_W-1:1]});
        rd_take_s     = RAM_RD_EN && !RAM_RDaddr_rst && !busy_r;
`ifdef NOISE_ACQ_MC_ACCUM_EN
        wdata_s = (scan_r == 8'd0) ? DATA_W'(sample_s) : rmw_word_r + DATA_W'(sample_s);
`else
        wdata_s = DATA_W'(sample_s);
`endif
    end

    // Datapath: run configuration, divider, capture, write indexing, readout
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_r        <= {DIV_W{1'b0}};
            div_cnt_r    <= {DIV_W{1'b0}};
            limit_r      <= {LIM_W{1'b0}};
            sample_idx_r <= {LIM_W{1'b0}};
            wr_addr_r    <= {ADDR_W{1'b0}};
            rd_addr_r    <= {ADDR_W{1'b0}};
            ch_r         <= {CH_W{1'b0}};
            hold_r       <= {(NUM_CH*ADC_W){1'b0}};
            ram_data_r   <= {DATA_W{1'b0}};
            rd_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            acq_clk_r    <= 1'b0;
`ifdef NOISE_ACQ_MC_ACCUM_EN
            scans_r      <= 8'd1;
            scan_r       <= 8'd0;
            phase_r      <= 1'b0;
`endif
        end else begin
            if (noise_load) begin
                div_r <= (n_divnum < D_MIN_C) ? D_MIN_C : n_divnum;
                if (acq_ext_s > MAX_C) begin
                    limit_r    <= MAX_C;
                    overflow_r <= 1'b1;
                end else begin
                    limit_r    <= acq_ext_s;
                    overflow_r <= 1'b0;
                end
`ifdef NOISE_ACQ_MC_ACCUM_EN
                scans_r <= (n_scans == 8'd0) ? 8'd1 : n_scans;
`endif
            end
            div_cnt_r <= cnt_nxt_s;
            acq_clk_r <= acq_clk_nxt_s;
            busy_r    <= busy_nxt_s;
            if (noise_load) begin
                done_r <= 1'b0;
            end else if (state_s == ST_DONE) begin
                done_r <= 1'b1;
            end
            if (strobe_s) begin
                hold_r <= n_ADC;
            end
            if (arm_s) begin
                sample_idx_r <= {LIM_W{1'b0}};
                wr_addr_r    <= {ADDR_W{1'b0}};
                ch_r         <= {CH_W{1'b0}};
`ifdef NOISE_ACQ_MC_ACCUM_EN
                scan_r       <= 8'd0;
`endif
            end else if (step_s) begin
                wr_addr_r <= wr_addr_r + ADDR_W'(1);
                if (ch_r == LAST_CH_C) begin
                    ch_r <= {CH_W{1'b0}};
                    if (scan_end_s) begin
                        // next scan revisits the same words from address 0
                        sample_idx_r <= {LIM_W{1'b0}};
                        wr_addr_r    <= {ADDR_W{1'b0}};
`ifdef NOISE_ACQ_MC_ACCUM_EN
                        scan_r       <= scan_r + 8'd1;
`endif
                    end else begin
                        sample_idx_r <= sample_idx_r + LIM_W'(1);
                    end
                end else begin
                    ch_r <= ch_r + CH_W'(1);
                end
            end
`ifdef NOISE_ACQ_MC_ACCUM_EN
            phase_r <= (state_r == ST_WRITE) ? ~phase_r : 1'b0;
`endif
            if (RAM_RDaddr_rst) begin
                rd_addr_r <= {ADDR_W{1'b0}};
            end else if (rd_take_s) begin
                rd_addr_r <= rd_addr_r + ADDR_W'(1);
            end
            rd_valid_r <= rd_take_s;
            if (rd_take_s) begin
                ram_data_r <= mem_r[rd_addr_r];
            end
        end
    end

    // Buffer RAM write port (and read-modify-write fetch when accumulating)
    always_ff @(posedge clk_sys) begin
        if (mem_we_s) begin
            mem_r[wr_addr_r] <= wdata_s;
        end
`ifdef NOISE_ACQ_MC_ACCUM_EN
        rmw_word_r <= mem_r[wr_addr_r];
`endif
    end

    assign Noise_acq_clk = acq_clk_r;
    assign RAM_data      = ram_data_r;
    assign rd_valid      = rd_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_noise_acq_mc.sv
// -----------------------------------------------------------------------------
// tb_noise_acq_mc
// Self-checking bench for noise_acq_mc (default parameters: NUM_CH=2, ADC_W=12,
// DATA_W=16, ADDR_W=10). A table of acquisition runs checks divider timing,
// sample count, done latency and overflow. Hand-written sequences then cover
// readout, restart, read-address reset, reset during a run and, when
// NOISE_ACQ_MC_ACCUM_EN is defined, accumulation.
// Samples for strobe k are ch0 = base+k and ch1 = 0x100+base+k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noise_acq_mc;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        noise_load;
    logic [11:0] n_acqnum;
    logic [9:0]  n_divnum;
    logic [23:0] n_ADC;
    logic        RAM_RD_EN;
    logic        RAM_RDaddr_rst;
    logic        Noise_acq_clk;
    logic [15:0] RAM_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef NOISE_ACQ_MC_ACCUM_EN
    logic [7:0]  n_scans;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    noise_acq_mc dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .noise_load     (noise_load),
        .n_acqnum       (n_acqnum),
        .n_divnum       (n_divnum),
        .n_ADC          (n_ADC),
`ifdef NOISE_ACQ_MC_ACCUM_EN
        .n_scans        (n_scans),
`endif
        .RAM_RD_EN      (RAM_RD_EN),
        .RAM_RDaddr_rst (RAM_RDaddr_rst),
        .Noise_acq_clk  (Noise_acq_clk),
        .RAM_data       (RAM_data),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [9:0]  div;
        logic [11:0] acq;
        int          lat;       // cycles from the load cycle to done visible
        int          rises;     // rising edges of Noise_acq_clk during the run
        int          period;    // cycles between 2nd and 3rd rising edge
        int          high;      // high cycles following the 2nd rising edge
        logic        ovf;
        int          rd_words;  // words to read back afterwards (0 = none)
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_adc(input int v);
        logic [31:0] t0, t1;
        t0 = v;
        t1 = v + 32'h100;
        n_ADC = {t1[11:0], t0[11:0]};
    endtask

    function automatic logic [31:0] exp_word(input int j, input int base);
        int k;
        k = (j % 1024) / 2;
        if ((j % 2) == 0) return (base + k) & 32'hFFF;
        else              return (32'h100 + base + k) & 32'hFFF;
    endfunction

    // Pulse noise_load and watch the run until done (or until abort_at rising
    // edges of Noise_acq_clk have been seen). lat = -1 if the budget expires.
    task automatic run_acq(input logic [9:0] div, input logic [11:0] acq, input int base,
                           input bit hold_adc, input int abort_at,
                           output int lat, output int rises, output int period, output int high);
        logic prev;
        int   r2, r3;
        lat = -1; rises = 0; period = -1; high = 0; r2 = 0; r3 = 0;
        n_divnum   = div;
        n_acqnum   = acq;
        set_adc(base);
        noise_load = 1'b1;
        tick();
        noise_load = 1'b0;
        prev = 1'b0;
        for (int c = 1; c <= 4000; c++) begin
            if (Noise_acq_clk && !prev) begin
                rises++;
                if (!hold_adc) set_adc(base + rises - 1);
                if (rises == 2) r2 = c;
                if (rises == 3) r3 = c;
            end
            if ((rises == 2) && Noise_acq_clk) high++;
            prev = Noise_acq_clk;
            if ((abort_at != 0) && (rises == abort_at)) begin
                lat = c;
                break;
            end
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
        if (r3 > 0) period = r3 - r2;
    endtask

    task automatic read_words(input int n, input int base);
        logic [31:0] last;
        last = 32'd0;
        RAM_RDaddr_rst = 1'b1;
        tick();
        RAM_RDaddr_rst = 1'b0;
        for (int j = 0; j < n; j++) begin
            RAM_RD_EN = 1'b1;
            tick();
            last = exp_word(j, base);
            check($sformatf("rd_valid[%0d]", j), rd_valid, 32'd1);
            check($sformatf("word[%0d]", j), RAM_data, last);
        end
        RAM_RD_EN = 1'b0;
        tick();
        check("rd_valid_idle", rd_valid, 32'd0);
        check("ram_data_hold", RAM_data, last);
    endtask

    initial begin
        int lat, rises, period, high;
        reset = 1'b1; noise_load = 1'b0; n_acqnum = 12'd0; n_divnum = 10'd0;
        n_ADC = 24'd0; RAM_RD_EN = 1'b0; RAM_RDaddr_rst = 1'b0;
`ifdef NOISE_ACQ_MC_ACCUM_EN
        n_scans = 8'd1;
`endif
        repeat (2) @(posedge clk_sys);
        #3 reset = 1'b0;
        tick();
        check("rst_acq_clk", Noise_acq_clk, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_rd_valid", rd_valid, 32'd0);
        check("rst_ram_data", RAM_data, 32'd0);

`ifdef NOISE_ACQ_MC_ACCUM_EN
        // divisor floor 5, four write cycles per sample
        vecs[0] = '{10'd10, 12'd4,   46,   5,   10, 5, 1'b0, 8};
        vecs[1] = '{10'd1,  12'd3,   21,   4,   5,  2, 1'b0, 0};
        vecs[2] = '{10'd0,  12'd2,   16,   3,   5,  2, 1'b0, 0};
        vecs[3] = '{10'd7,  12'd3,   27,   4,   7,  3, 1'b0, 0};
        vecs[4] = '{10'd4,  12'd0,   2,    0,   0,  0, 1'b0, 0};
        vecs[5] = '{10'd3,  12'd600, 2566, 513, 5,  2, 1'b1, 1025};
`else
        // divisor floor 3, two write cycles per sample
        vecs[0] = '{10'd10, 12'd4,   44,   5,   10, 5, 1'b0, 8};
        vecs[1] = '{10'd1,  12'd3,   13,   4,   3,  1, 1'b0, 0};
        vecs[2] = '{10'd0,  12'd2,   10,   3,   3,  1, 1'b0, 0};
        vecs[3] = '{10'd7,  12'd3,   25,   4,   7,  3, 1'b0, 0};
        vecs[4] = '{10'd4,  12'd0,   2,    0,   0,  0, 1'b0, 0};
        vecs[5] = '{10'd3,  12'd600, 1540, 513, 3,  1, 1'b1, 1025};
`endif

        for (int i = 0; i < 6; i++) begin
            run_acq(vecs[i].div, vecs[i].acq, 0, 1'b0, 0, lat, rises, period, high);
            check($sformatf("v%0d_done_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_clk_rises", i), rises, vecs[i].rises);
            if (vecs[i].rises >= 3) begin
                check($sformatf("v%0d_clk_period", i), period, vecs[i].period);
                check($sformatf("v%0d_clk_high", i), high, vecs[i].high);
            end
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d_busy_at_done", i), busy, 32'd0);
            if (vecs[i].rd_words > 0) read_words(vecs[i].rd_words, 0);
        end

        // Restart after two strobes: done/overflow (set by the last run) clear,
        // reads are ignored while busy, and the new run starts at address 0.
        run_acq(10'd10, 12'd4, 'h20, 1'b0, 3, lat, rises, period, high);
        check("restart_abort_point", rises, 32'd3);
        check("restart_busy", busy, 32'd1);
        check("restart_done_clr", done, 32'd0);
        check("restart_ovf_clr", overflow, 32'd0);
        RAM_RD_EN = 1'b1;
        tick();
        RAM_RD_EN = 1'b0;
        check("rd_while_busy", rd_valid, 32'd0);
        run_acq(10'd10, 12'd3, 'h40, 1'b0, 0, lat, rises, period, high);
`ifdef NOISE_ACQ_MC_ACCUM_EN
        check("restart_latency", lat, 32'd36);
`else
        check("restart_latency", lat, 32'd34);
`endif
        check("restart_ovf", overflow, 32'd0);
        read_words(6, 'h40);

        // Address reset together with a read request: reset wins, no read
        RAM_RDaddr_rst = 1'b1;
        RAM_RD_EN      = 1'b1;
        tick();
        RAM_RDaddr_rst = 1'b0;
        RAM_RD_EN      = 1'b0;
        check("rst_and_rd_valid", rd_valid, 32'd0);
        check("rst_and_rd_hold", RAM_data, exp_word(5, 'h40));
        RAM_RD_EN = 1'b1;
        tick();
        RAM_RD_EN = 1'b0;
        check("after_addr_rst_valid", rd_valid, 32'd1);
        check("after_addr_rst_word0", RAM_data, 32'h40);

`ifdef NOISE_ACQ_MC_ACCUM_EN
        // Three scans of a constant 0x7FF on ch0 accumulate into word 0
        n_scans = 8'd3;
        run_acq(10'd0, 12'd1, 'h7FF, 1'b1, 0, lat, rises, period, high);
        check("accum_finished", done, 32'd1);
        n_scans = 8'd1;
        RAM_RDaddr_rst = 1'b1;
        tick();
        RAM_RDaddr_rst = 1'b0;
        RAM_RD_EN = 1'b1;
        tick();
        RAM_RD_EN = 1'b0;
        check("accum_word0", RAM_data, 32'h17FD);
`endif

        // Reset at the third strobe of a run
        run_acq(10'd10, 12'd8, 0, 1'b0, 4, lat, rises, period, high);
        check("midrst_abort_point", rises, 32'd4);
        reset = 1'b1;
        #1;
        check("midrst_acq_clk", Noise_acq_clk, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_done", done, 32'd0);
        check("midrst_overflow", overflow, 32'd0);
        check("midrst_rd_valid", rd_valid, 32'd0);
        check("midrst_ram_data", RAM_data, 32'd0);
        #1 reset = 1'b0;
        tick();
        check("postrst_busy", busy, 32'd0);
        check("postrst_acq_clk", Noise_acq_clk, 32'd0);
        RAM_RD_EN = 1'b1;
        tick();
        RAM_RD_EN = 1'b0;
        check("postrst_rd_valid", rd_valid, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/noise_acq_mc.md
Name: noise_acq_mc

Overview:
- Parametrised multi-channel successor of the single-channel noise acquisition block.
- Divides clk_sys into a programmable ADC sample strobe and captures NUM_CH ADC channels per strobe. Writes samples channel-interleaved into an internal buffer RAM, then serves sequential readout to the host read path.
- Sits between the ADC front-end and the host data bus in the noise-measurement path.

Parameters:
- NUM_CH, 2, channels captured per sample strobe (1..8)
- ADC_W, 12, ADC sample width per channel
- DATA_W, 16, RAM word / readout width (>= ADC_W); samples zero-extended
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W words
- CNT_W, 12, acquisition-count width
- DIV_W, 10, divider width

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- noise_load  in  1  1-cycle pulse: latch n_acqnum/n_divnum, start acquisition
- n_acqnum  in  CNT_W  samples per channel to acquire
- n_divnum  in  DIV_W  clk_sys cycles per sample strobe
- n_ADC  in  NUM_CH*ADC_W  channel samples; ch0 in LSBs
- RAM_RD_EN  in  1  readout request; one word per asserted cycle
- RAM_RDaddr_rst  in  1  synchronous clear of read address to 0
- Noise_acq_clk  out  1  divided sample clock to ADC
- RAM_data  out  DATA_W  readout word
- rd_valid  out  1  RAM_data valid, 1 cycle after accepted RAM_RD_EN
- busy  out  1  acquisition in progress
- done  out  1  level: acquisition complete; cleared by next noise_load
- overflow  out  1  n_acqnum*NUM_CH exceeded depth; sticky until noise_load

Behaviour:
- Reset: state IDLE; all counters, read address, RAM_data, rd_valid, busy, done, overflow, Noise_acq_clk = 0. RAM contents undefined.
- Effective divisor D = max(n_divnum, NUM_CH+1), latched at noise_load. Clamp also applies to n_divnum = 0.
- Divider counts 0..D-1 while busy. Noise_acq_clk = 1 for count < D/2 (integer division), else 0. Strobe fires at count == D-1, coinciding with the rising edge of Noise_acq_clk on the next cycle.
- Limit L = min(n_acqnum, floor(2**ADDR_W / NUM_CH)). overflow = 1 if clamped. n_acqnum = 0: done asserts 2 cycles after load, nothing written.
- FSM:
  - IDLE --noise_load--> ARM.
  - ARM (1 cycle): clear sample index, write address, divider; busy = 1 → WAIT.
  - WAIT: on strobe, register all NUM_CH samples into holding register → WRITE.
  - WRITE: write one channel per cycle, ch0 first; address = sample_idx*NUM_CH + ch. After the last channel, sample_idx++. Go to DONE if sample_idx == L, else WAIT.
  - DONE: busy = 0, done = 1, Noise_acq_clk held 0 → IDLE.
- noise_load while busy: restart (abort current run, go to ARM, clear overflow/done). Written data from the aborted run is discarded logically.
- Readout: RAM_RD_EN accepted only when busy = 0; ignored while busy (rd_valid stays 0). Accepted read returns word[rd_addr] on RAM_data with rd_valid = 1 the next cycle; rd_addr then increments, wrapping 2**ADDR_W-1 → 0.
- RAM_RDaddr_rst and RAM_RD_EN in the same cycle: reset wins, no read issued. RAM_data holds its last value when not reading.

Optional Feature:
- Macro NOISE_ACQ_MC_ACCUM_EN.
- Defined:
  - Extra input n_scans (8 bits). Acquisition repeats n_scans times (0 treated as 1).
  - Scan 1 writes samples. Later scans read-modify-write: word = word + sample, wrapping modulo 2**DATA_W. 2 cycles per channel, so D = max(n_divnum, 2*NUM_CH+1).
  - done asserts after the last scan.
- Undefined: single scan, no n_scans port, D as above.

Test Plan:
- Reset mid-acquisition (assert at 3rd strobe) → all outputs 0 next cycle; RAM_RD_EN thereafter returns no rd_valid until busy = 0 (already 0).
- NUM_CH=2, n_divnum=10, n_acqnum=4, n_ADC = {ch1 = 0x100 + k, ch0 = k} for strobe k → Noise_acq_clk period 10 with 5 high. done after 4 strobes. Readout of 8 words = 0,0x100,1,0x101,2,0x102,3,0x103.
- n_divnum=1 with NUM_CH=2 → clamped D=3, strobe every 3 cycles; n_divnum=0 → same.
- n_acqnum=600, ADDR_W=10, NUM_CH=2 → L=512, overflow=1, done after 512 strobes. Readout word 1023 then wrap to word 0.
- noise_load re-pulsed after 2 strobes → done/overflow cleared, sample index restarts at address 0. RAM_RD_EN during busy → no rd_valid. RAM_RDaddr_rst + RAM_RD_EN same cycle → address 0, no read.
- ACCUM_EN, n_scans=3, constant ch0 sample 0x7FF, DATA_W=12 → word0 = 0x7FF*3 mod 4096 = 0x7FD.
